// File: rtl/lighting_pipe.sv
// Three-stage diffuse lighting pipeline: per-light clamped N.L, ambient-floored
// intensity saturated at 1.0, then per-channel RGB444 scaling on a valid/ready stream.
package lighting_pipe_pkg;
  typedef struct packed {
    logic signed [15:0] i;
    logic signed [15:0] j;
    logic signed [15:0] k;
  } Vector_t;

  typedef struct packed {
    logic [15:0] id;
    Vector_t     normal;
    logic [11:0] color;
  } Face_t;
endpackage

module lighting_pipe
  import lighting_pipe_pkg::*;
#(
  parameter int          NUM_LIGHTS = 4,
  parameter logic [15:0] AMBIENT    = 16'h0020,
  parameter bit          TWO_SIDED  = 1'b0,
  localparam int         IDX_W      = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  Face_t                 face_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output Face_t                 face_o,
  input  logic                  light_wr_en,
  input  logic [IDX_W-1:0]      light_wr_idx,
  input  Vector_t               light_wr_vec,
  input  logic [NUM_LIGHTS-1:0] light_en,
  output logic [15:0]           faces_done
);

  localparam int SW = 16 + IDX_W + 1;

  function automatic logic [15:0] mul(input logic signed [15:0] a, input logic signed [15:0] b);
    logic signed [31:0] p;
    p = 32'(a) * 32'(b);
    return 16'(p >>> 8);
  endfunction

  function automatic logic [15:0] dot(input Vector_t n, input Vector_t l);
    return mul(n.i, l.i) + mul(n.j, l.j) + mul(n.k, l.k);
  endfunction

  // Negative results clamp to zero or fold to |d|; -0x8000 has no positive twin so it pins at 0x7FFF.
  function automatic logic [15:0] term(input logic [15:0] d, input logic en);
    logic [15:0] t;
    if (!en) begin
      t = 16'h0000;
    end else if (!d[15]) begin
      t = d;
    end else if (TWO_SIDED) begin
      t = (d == 16'h8000) ? 16'h7FFF : (16'h0000 - d);
    end else begin
      t = 16'h0000;
    end
    return t;
  endfunction

  function automatic logic [3:0] scale(input logic [3:0] c, input logic [8:0] inten);
    logic [12:0] p;
    p = 13'(c) * 13'(inten);
    return 4'(p >> 8);
  endfunction

  Vector_t     lights_q   [NUM_LIGHTS];
  logic        s1_valid_q, s2_valid_q, out_valid_q;
  Face_t       s1_face_q, s2_face_q, face_q, face_d;
  logic [15:0] s1_term_d  [NUM_LIGHTS];
  logic [15:0] s1_term_q  [NUM_LIGHTS];
  logic [8:0]  s2_int_d, s2_int_q;
  logic [SW-1:0] sum_s;
  logic [15:0] faces_done_q;
  logic        stall_s;

  assign stall_s    = out_valid_q && !out_ready;
  assign in_ready   = !stall_s;
  assign out_valid  = out_valid_q;
  assign face_o     = face_q;
  assign faces_done = faces_done_q;

  always_comb begin
    for (int l = 0; l < NUM_LIGHTS; l++) begin
      s1_term_d[l] = term(dot(face_i.normal, lights_q[l]), light_en[l]);
    end
  end

  always_comb begin
    sum_s = SW'(AMBIENT);
    for (int l = 0; l < NUM_LIGHTS; l++) begin
      sum_s = sum_s + SW'(s1_term_q[l]);
    end
    if (sum_s > SW'(9'h100)) begin
      s2_int_d = 9'h100;
    end else begin
      s2_int_d = sum_s[8:0];
    end
  end

  always_comb begin
    face_d       = s2_face_q;
    face_d.color = {scale(s2_face_q.color[11:8], s2_int_q),
                    scale(s2_face_q.color[7:4],  s2_int_q),
                    scale(s2_face_q.color[3:0],  s2_int_q)};
  end

  // Light writes ignore the stall so the control side is never blocked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < NUM_LIGHTS; l++) begin
        lights_q[l] <= '0;
      end
    end else if (light_wr_en && (int'(light_wr_idx) < NUM_LIGHTS)) begin
      lights_q[light_wr_idx] <= light_wr_vec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s1_face_q   <= '0;
      s2_face_q   <= '0;
      face_q      <= '0;
      s2_int_q    <= 9'h000;
      for (int l = 0; l < NUM_LIGHTS; l++) begin
        s1_term_q[l] <= 16'h0000;
      end
    end else if (!stall_s) begin
      s1_valid_q  <= in_valid;
      s2_valid_q  <= s1_valid_q;
      out_valid_q <= s2_valid_q;
      s2_face_q   <= s1_face_q;
      s2_int_q    <= s2_int_d;
      face_q      <= face_d;
      if (in_valid) begin
        s1_face_q <= face_i;
        for (int l = 0; l < NUM_LIGHTS; l++) begin
          s1_term_q[l] <= s1_term_d[l];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      faces_done_q <= 16'h0000;
    end else if (out_valid_q && out_ready) begin
      faces_done_q <= faces_done_q + 16'h0001;
    end
  end

endmodule
